// File: rtl/arbitro_br_pkg.sv
// Shared widths, source encoding and constants for the BR write-port arbiter
// and its hazard scoreboard.
package arbitro_br_pkg;

  localparam int ANCHO_DATO = 32;
  localparam int ANCHO_DIR  = 5;
  localparam int NUM_REGS   = 1 << ANCHO_DIR;

  localparam logic [ANCHO_DIR-1:0] REG_CERO = '0;

  typedef enum logic {
    FUENTE_ALU = 1'b0,
    FUENTE_MEM = 1'b1
  } fuente_e;

endpackage : arbitro_br_pkg

// File: rtl/arbitro_br_if.sv
// Bundle of writeback handshakes, issue/read addresses and BR write port.
// master = the pipeline side driving requests; slave = the arbiter.
interface arbitro_br_if;
  import arbitro_br_pkg::*;

  logic                  alu_valid;
  logic [ANCHO_DIR-1:0]  alu_dir;
  logic [ANCHO_DATO-1:0] alu_dato;
  logic                  alu_ready;

  logic                  mem_valid;
  logic [ANCHO_DIR-1:0]  mem_dir;
  logic [ANCHO_DATO-1:0] mem_dato;
  logic                  mem_ready;

  logic                  emit_en;
  logic [ANCHO_DIR-1:0]  emit_dir;
  logic [ANCHO_DIR-1:0]  RA1;
  logic [ANCHO_DIR-1:0]  RA2;
  logic                  stall;

  logic                  RegEn;
  logic [ANCHO_DIR-1:0]  Dir;
  logic [ANCHO_DATO-1:0] Di;

  modport master (
    output alu_valid, alu_dir, alu_dato, input alu_ready,
    output mem_valid, mem_dir, mem_dato, input mem_ready,
    output emit_en, emit_dir, RA1, RA2, input stall,
    input  RegEn, Dir, Di
  );

  modport slave (
    input  alu_valid, alu_dir, alu_dato, output alu_ready,
    input  mem_valid, mem_dir, mem_dato, output mem_ready,
    input  emit_en, emit_dir, RA1, RA2, output stall,
    output RegEn, Dir, Di
  );

endinterface : arbitro_br_if

// File: rtl/arbitro_br_marcador.sv
// Scoreboard of registers with a write in flight; flags read hazards on RA1/RA2.
module marcador_br
  import arbitro_br_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en_i,
  input  logic [ANCHO_DIR-1:0] set_dir_i,
  input  logic                 clr_en_i,
  input  logic [ANCHO_DIR-1:0] clr_dir_i,
  input  logic [ANCHO_DIR-1:0] ra1_i,
  input  logic [ANCHO_DIR-1:0] ra2_i,
  output logic                 stall_o
);

  logic [NUM_REGS-1:0] pendiente_q, pendiente_d;

  // Set applied after clear: a newly issued producer outranks a retiring one.
  always_comb begin
    pendiente_d = pendiente_q;
    if (clr_en_i) pendiente_d[clr_dir_i] = 1'b0;
    if (set_en_i) pendiente_d[set_dir_i] = 1'b1;
  end

  // NOTE: this vector is control state, so it is reset, unlike a plain data array.
  always_ff @(posedge clk) begin
    if (rst) pendiente_q <= '0;
    else     pendiente_q <= pendiente_d;
  end

  assign stall_o = ((ra1_i != REG_CERO) && pendiente_q[ra1_i]) ||
                   ((ra2_i != REG_CERO) && pendiente_q[ra2_i]);

endmodule : marcador_br

// File: rtl/arbitro_br.sv
// Round-robin arbiter sharing the BR write port between ALU and memory
// writebacks, with a one-cycle registered output stage and hazard scoreboard.
module arbitro_br
  import arbitro_br_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  arbitro_br_if.slave  bus
);

  fuente_e               ultimo_q, ultimo_d;
  logic                  grant_alu, grant_mem;
  logic                  regen_q, regen_d;
  logic [ANCHO_DIR-1:0]  dir_q, dir_d;
  logic [ANCHO_DATO-1:0] di_q, di_d;

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    ultimo_d  = ultimo_q;
    regen_d   = 1'b0;
    dir_d     = dir_q;
    di_d      = di_q;

    // On a tie the source that did not win last time is served.
    if (!rst) begin
      if (bus.alu_valid && (!bus.mem_valid || ultimo_q == FUENTE_MEM)) grant_alu = 1'b1;
      else if (bus.mem_valid)                                          grant_mem = 1'b1;
    end

    if (grant_alu) begin
      ultimo_d = FUENTE_ALU;
      regen_d  = (bus.alu_dir != REG_CERO);
      dir_d    = bus.alu_dir;
      di_d     = bus.alu_dato;
    end else if (grant_mem) begin
      ultimo_d = FUENTE_MEM;
      regen_d  = (bus.mem_dir != REG_CERO);
      dir_d    = bus.mem_dir;
      di_d     = bus.mem_dato;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ultimo_q <= FUENTE_ALU;
      regen_q  <= 1'b0;
      dir_q    <= '0;
      di_q     <= '0;
    end else begin
      ultimo_q <= ultimo_d;
      regen_q  <= regen_d;
      dir_q    <= dir_d;
      di_q     <= di_d;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign bus.RegEn     = regen_q;
  assign bus.Dir       = dir_q;
  assign bus.Di        = di_q;

  marcador_br u_marcador (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (bus.emit_en && (bus.emit_dir != REG_CERO)),
    .set_dir_i (bus.emit_dir),
    .clr_en_i  (regen_q),
    .clr_dir_i (dir_q),
    .ra1_i     (bus.RA1),
    .ra2_i     (bus.RA2),
    .stall_o   (bus.stall)
  );

endmodule : arbitro_br

// File: tb/tb_arbitro_br.sv
// Directed bench for arbitro_br: a behavioural model checked every cycle plus
// literal expectations for each scenario.
module tb_arbitro_br;
  import arbitro_br_pkg::*;

  logic clk;
  logic rst;
  arbitro_br_if bus ();

  arbitro_br dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: who won last, which registers await a write, what BR sees now.
  bit                    m_pend [NUM_REGS];
  bit                    m_last_mem;
  bit                    m_regen;
  logic [ANCHO_DIR-1:0]  m_dir;
  logic [ANCHO_DATO-1:0] m_di;
  bit                    model_ok = 1'b0;
  int                    grant_log [$];

  function automatic bit exp_alu_ready();
    return !rst && bus.alu_valid && (!bus.mem_valid || m_last_mem);
  endfunction

  function automatic bit exp_mem_ready();
    return !rst && bus.mem_valid && (!bus.alu_valid || !m_last_mem);
  endfunction

  function automatic bit exp_stall();
    return (bus.RA1 != 0 && m_pend[bus.RA1]) || (bus.RA2 != 0 && m_pend[bus.RA2]);
  endfunction

  always @(posedge clk) begin
    bit ga, gm;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_last_mem = 1'b0;
      m_regen    = 1'b0;
      m_dir      = '0;
      m_di       = '0;
    end else begin
      ga = exp_alu_ready();
      gm = exp_mem_ready();
      if (m_regen) m_pend[m_dir] = 1'b0;
      if (bus.emit_en && bus.emit_dir != 0) m_pend[bus.emit_dir] = 1'b1;
      if (ga) begin
        grant_log.push_back(int'(bus.alu_dir));
        m_last_mem = 1'b0;
        m_regen    = (bus.alu_dir != 0);
        m_dir      = bus.alu_dir;
        m_di       = bus.alu_dato;
      end else if (gm) begin
        grant_log.push_back(100 + int'(bus.mem_dir));
        m_last_mem = 1'b1;
        m_regen    = (bus.mem_dir != 0);
        m_dir      = bus.mem_dir;
        m_di       = bus.mem_dato;
      end else begin
        m_regen = 1'b0;
      end
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("alu_ready", 64'(bus.alu_ready), 64'(exp_alu_ready()));
      check("mem_ready", 64'(bus.mem_ready), 64'(exp_mem_ready()));
      check("stall",     64'(bus.stall),     64'(exp_stall()));
      check("RegEn",     64'(bus.RegEn),     64'(m_regen));
      check("Dir",       64'(bus.Dir),       64'(m_dir));
      check("Di",        64'(bus.Di),        64'(m_di));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ai, mi;
    bit a_acc, m_acc;
    int exp_log [4] = '{111, 1, 112, 2};

    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_dir = '0; bus.alu_dato = '0;
    bus.mem_valid = 1'b0; bus.mem_dir = '0; bus.mem_dato = '0;
    bus.emit_en = 1'b0; bus.emit_dir = '0; bus.RA1 = '0; bus.RA2 = '0;

    // Reset with both sources requesting
    bus.alu_valid = 1'b1; bus.alu_dir = 5'd3; bus.alu_dato = 32'hA3;
    bus.mem_valid = 1'b1; bus.mem_dir = 5'd4; bus.mem_dato = 32'hB4;
    tick();
    @(negedge clk);
    check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
    check("rst_RegEn",     64'(bus.RegEn),     64'd0);
    check("rst_stall",     64'(bus.stall),     64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("first_tie_mem", 64'(bus.mem_ready), 64'd1);
    check("first_tie_alu", 64'(bus.alu_ready), 64'd0);
    tick();
    bus.mem_valid = 1'b0;
    @(negedge clk);
    check("after_tie_alu", 64'(bus.alu_ready), 64'd1);
    check("after_tie_Dir", 64'(bus.Dir),       64'd4);
    tick();
    bus.alu_valid = 1'b0;
    tick();

    // Single ALU write
    bus.alu_valid = 1'b1; bus.alu_dir = 5'd5; bus.alu_dato = 32'hDEADBEEF;
    @(negedge clk);
    check("single_ready", 64'(bus.alu_ready), 64'd1);
    tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    check("single_RegEn", 64'(bus.RegEn), 64'd1);
    check("single_Dir",   64'(bus.Dir),   64'd5);
    check("single_Di",    64'(bus.Di),    64'hDEADBEEF);
    tick();
    @(negedge clk);
    check("single_RegEn_off", 64'(bus.RegEn), 64'd0);
    tick();

    // Contention: each source holds its request until accepted
    grant_log.delete();
    ai = 0; mi = 0;
    bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.alu_dir  = ANCHO_DIR'(1 + ai);  bus.alu_dato = 32'hA000 + ai;
      bus.mem_dir  = ANCHO_DIR'(11 + mi); bus.mem_dato = 32'hB000 + mi;
      @(negedge clk);
      a_acc = bus.alu_ready; m_acc = bus.mem_ready;
      tick();
      if (a_acc) ai++;
      if (m_acc) mi++;
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    check("contention_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("contention_order%0d", i),
            64'(i < grant_log.size() ? grant_log[i] : -1), 64'(exp_log[i]));
    tick();

    // Hazard on register 7
    bus.emit_en = 1'b1; bus.emit_dir = 5'd7; bus.RA1 = 5'd7; bus.RA2 = 5'd0;
    @(negedge clk);
    check("hazard_before_set", 64'(bus.stall), 64'd0);
    tick();
    bus.emit_en = 1'b0;
    @(negedge clk);
    check("hazard_set", 64'(bus.stall), 64'd1);
    tick();
    bus.RA1 = 5'd0; bus.RA2 = 5'd7;
    @(negedge clk);
    check("hazard_ra2", 64'(bus.stall), 64'd1);
    tick();
    bus.RA1 = 5'd7; bus.RA2 = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_dir = 5'd7; bus.alu_dato = 32'h77;
    @(negedge clk);
    check("hazard_N", 64'(bus.stall), 64'd1);
    tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    check("hazard_N1_stall", 64'(bus.stall), 64'd1);
    check("hazard_N1_Dir",   64'(bus.Dir),   64'd7);
    tick();
    @(negedge clk);
    check("hazard_N2_stall", 64'(bus.stall), 64'd0);
    tick();

    // Register zero
    bus.mem_valid = 1'b1; bus.mem_dir = 5'd0; bus.mem_dato = 32'h1234;
    bus.emit_en = 1'b1; bus.emit_dir = 5'd0; bus.RA1 = 5'd0;
    @(negedge clk);
    check("zero_ready", 64'(bus.mem_ready), 64'd1);
    tick();
    bus.mem_valid = 1'b0; bus.emit_en = 1'b0;
    @(negedge clk);
    check("zero_RegEn", 64'(bus.RegEn), 64'd0);
    check("zero_stall", 64'(bus.stall), 64'd0);
    tick();

    // Simultaneous set and clear of register 9
    bus.emit_en = 1'b1; bus.emit_dir = 5'd9; bus.RA1 = 5'd9;
    tick();
    bus.emit_en = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dir = 5'd9; bus.alu_dato = 32'h99;
    tick();
    bus.alu_valid = 1'b0;
    bus.emit_en = 1'b1; bus.emit_dir = 5'd9;
    @(negedge clk);
    check("setclr_RegEn", 64'(bus.RegEn), 64'd1);
    tick();
    bus.emit_en = 1'b0;
    @(negedge clk);
    check("setclr_persist", 64'(bus.stall), 64'd1);
    tick();
    bus.mem_valid = 1'b1; bus.mem_dir = 5'd9; bus.mem_dato = 32'h999;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    @(negedge clk);
    check("setclr_retired", 64'(bus.stall), 64'd0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_arbitro_br
